// File: rtl/ahb_slave_front.sv
// AHB front end of the AHB2APB bridge: qualifies and decodes transfers, then queues them for the APB FSM.
// Define ERR_RESP_EN to build the two-cycle ERROR response for accesses outside the bridge window.
module ahb_slave_front #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] SEL_SPAN  = 32'h0400_0000,
    parameter int unsigned NUM_SEL   = 3
) (
    input  logic               CLK,
    input  logic               HRESET,
    input  logic [31:0]        HADDR,
    input  logic               HWRITE,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HSIZE,
    input  logic [2:0]         HBURST,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY_IN,
    output logic               HREADY_OUT,
    output logic [1:0]         HRESP,
    output logic [31:0]        HRDATA,
    output logic               req_valid,
    input  logic               req_ready,
    output logic               req_write,
    output logic [31:0]        req_addr,
    output logic [31:0]        req_wdata,
    output logic [2:0]         req_size,
    output logic [NUM_SEL-1:0] req_sel,
    input  logic               rsp_valid,
    input  logic [31:0]        rsp_rdata
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [63:0] SPAN64 = {32'd0, SEL_SPAN};

    typedef enum logic [2:0] {
        ADDR,
        WDATA,
        RPUSH,
        RWAIT,
`ifdef ERR_RESP_EN
        RDONE,
        ERR1,
        ERR2
`else
        RDONE
`endif
    } state_t;

    state_t                state, state_next, addr_next;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      wptr, rptr;
    logic                  has_space, valid_xfer, push, push_write, pop;
    logic [31:0]           offset;
    logic                  in_range;
    logic [NUM_SEL-1:0]    sel_dec;
    logic [31:0]           addr_p1;
    logic [2:0]            size_p1;
    logic [NUM_SEL-1:0]    sel_p1;
    logic [31:0]           mem_addr  [DEPTH];
    logic [31:0]           mem_wdata [DEPTH];
    logic                  mem_write [DEPTH];
    logic [2:0]            mem_size  [DEPTH];
    logic [NUM_SEL-1:0]    mem_sel   [DEPTH];
    logic                  unused_inputs;

    assign unused_inputs = ^{HBURST, HTRANS[0]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Window and one-hot region decode of the current address phase
    always_comb begin
        offset   = HADDR - BASE_ADDR;
        in_range = (HADDR >= BASE_ADDR) && ({32'd0, offset} < SPAN64 * 64'(NUM_SEL));
        sel_dec  = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            sel_dec[i] = in_range && ({32'd0, offset} >= SPAN64 * 64'(i))
                                  && ({32'd0, offset} <  SPAN64 * 64'(i + 1));
        end
    end

    assign has_space  = (count < CNT_W'(DEPTH));
    assign valid_xfer = HREADY_IN && HREADY_OUT && HTRANS[1];
    assign req_valid  = (count != '0);
    assign pop        = req_valid && req_ready;
    assign push_write = (state == WDATA);

    // Address phase -> data phase boundary
    always_ff @(posedge CLK) begin
        if (valid_xfer) begin
            addr_p1 <= HADDR;
            size_p1 <= HSIZE;
            sel_p1  <= sel_dec;
        end
    end

    always_ff @(posedge CLK) begin
        if (HRESET) state <= ADDR;
        else        state <= state_next;
    end

    always_comb begin
        addr_next = ADDR;
        if (valid_xfer) begin
            if (!in_range) begin
`ifdef ERR_RESP_EN
                addr_next = ERR1;
`else
                addr_next = ADDR;
`endif
            end else if (HWRITE) begin
                addr_next = WDATA;
            end else begin
                addr_next = RPUSH;
            end
        end
        state_next = state;
        case (state)
            ADDR, RDONE: state_next = addr_next;
            WDATA:       if (has_space) state_next = addr_next;
            RPUSH:       if (has_space) state_next = RWAIT;
            RWAIT:       if (rsp_valid) state_next = RDONE;
`ifdef ERR_RESP_EN
            ERR1:        state_next = ERR2;
            ERR2:        state_next = addr_next;
`endif
            default:     state_next = ADDR;
        endcase
    end

    always_comb begin
        HREADY_OUT = 1'b1;
        HRESP      = 2'b00;
        push       = 1'b0;
        case (state)
            WDATA: begin
                HREADY_OUT = has_space;
                push       = has_space;
            end
            RPUSH: begin
                HREADY_OUT = 1'b0;
                push       = has_space;
            end
            RWAIT: HREADY_OUT = 1'b0;
`ifdef ERR_RESP_EN
            ERR1: begin
                HREADY_OUT = 1'b0;
                HRESP      = 2'b01;
            end
            ERR2: HRESP = 2'b01;
`endif
            default: ;
        endcase
    end

    // Out-of-range reads return zero; an in-order response lands only while a read waits
    always_ff @(posedge CLK) begin
        if (HRESET)                           HRDATA <= '0;
        else if (state == RWAIT && rsp_valid) HRDATA <= rsp_rdata;
        else if (valid_xfer && !in_range && !HWRITE) HRDATA <= '0;
    end

    // Data phase -> request FIFO boundary
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_addr[wptr]  <= addr_p1;
            mem_wdata[wptr] <= HWDATA;
            mem_write[wptr] <= push_write;
            mem_size[wptr]  <= size_p1;
            mem_sel[wptr]   <= sel_p1;
        end
    end

    always_ff @(posedge CLK) begin
        if (HRESET) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign req_addr  = mem_addr[rptr];
    assign req_wdata = mem_wdata[rptr];
    assign req_write = mem_write[rptr];
    assign req_size  = mem_size[rptr];
    assign req_sel   = mem_sel[rptr];
endmodule

// File: tb/tb_ahb_slave_front.sv
// Directed and randomized bench for ahb_slave_front; the random phase compares every popped request
// and every completed read against an in-order transaction model.
module tb_ahb_slave_front;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SPAN = 32'h0400_0000;
    localparam int          NSEL = 3;
`ifdef ERR_RESP_EN
    localparam bit ERR_BUILD = 1'b1;
`else
    localparam bit ERR_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        hreset = 1'b1;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = 2'd0;
    logic [2:0]  hsize = 3'd0;
    logic [2:0]  hburst = 3'd0;
    logic [31:0] hwdata = '0;
    logic        hready_in;
    logic        hready_out;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic [2:0]  req_sel;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  sel;
    } ent_t;
    ent_t exp_q[$];

    ahb_slave_front #(.DEPTH(2), .BASE_ADDR(BASE), .SEL_SPAN(SPAN), .NUM_SEL(NSEL)) dut (
        .CLK(clk), .HRESET(hreset), .HADDR(haddr), .HWRITE(hwrite), .HTRANS(htrans),
        .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY_IN(hready_in),
        .HREADY_OUT(hready_out), .HRESP(hresp), .HRDATA(hrdata),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    assign hready_in = hready_out;
    always #5 clk = ~clk;

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE) && ((64'(a) - 64'(BASE)) < 64'(NSEL) * 64'(SPAN));
    endfunction

    function automatic logic [2:0] exp_sel(input logic [31:0] a);
        return 3'(32'd1 << ((a - BASE) / SPAN));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [31:0] a, input logic w, input logic [1:0] t, input logic [2:0] s);
        haddr  = a;
        hwrite = w;
        htrans = t;
        hsize  = s;
    endtask

    task automatic do_reset();
        set_addr(32'd0, 1'b0, 2'd0, 3'd0);
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        hreset    = 1'b1;
        tick();
        tick();
        hreset = 1'b0;
    endtask

    task automatic rand_addr();
        logic [31:0] a;
        logic [31:0] off;
        int          r;
        int          t;
        r   = int'($urandom_range(0, 7));
        off = ($urandom_range(0, 3) == 0) ? SPAN - 32'd4 : 32'($urandom_range(0, 255)) * 32'd4;
        if (r < 6)       a = BASE + SPAN * 32'(r % NSEL) + off;
        else if (r == 6) a = BASE + SPAN * 32'(NSEL) + 32'($urandom_range(0, 3)) * 32'd4;
        else             a = BASE - 32'd4 - 32'($urandom_range(0, 3)) * 32'd4;
        t = int'($urandom_range(0, 5));
        set_addr(a, 1'($urandom_range(0, 1)), (t < 2) ? 2'(t) : 2'($urandom_range(2, 3)),
                 3'($urandom_range(0, 2)));
    endtask

    initial begin
        logic        hr, acc, dp_active, dp_read, dp_oor, rsp_wait;
        logic [31:0] dp_rdata, nxt_wdata;
        int          rsp_cnt;
        ent_t        e;

        // Reset values
        do_reset();
        check("rst_hready", 32'(hready_out), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        check("rst_req_valid", 32'(req_valid), 32'd0);

        // Single posted write
        req_ready = 1'b1;
        set_addr(32'h8000_0010, 1'b1, 2'd2, 3'd2);
        check("w1_addr_hready", 32'(hready_out), 32'd1);
        tick();
        set_addr(32'h8000_0010, 1'b0, 2'd0, 3'd2);
        hwdata = 32'hDEAD_BEEF;
        check("w1_data_hready", 32'(hready_out), 32'd1);
        check("w1_no_early_req", 32'(req_valid), 32'd0);
        tick();
        check("w1_req_valid", 32'(req_valid), 32'd1);
        check("w1_req_addr", req_addr, 32'h8000_0010);
        check("w1_req_wdata", req_wdata, 32'hDEAD_BEEF);
        check("w1_req_sel", 32'(req_sel), 32'd1);
        check("w1_req_write", 32'(req_write), 32'd1);
        check("w1_req_size", 32'(req_size), 32'd2);
        tick();
        check("w1_popped", 32'(req_valid), 32'd0);

        // FIFO full: three writes with the consumer stalled
        req_ready = 1'b0;
        set_addr(32'h8400_0000, 1'b1, 2'd2, 3'd2);
        tick();
        set_addr(32'h8400_0004, 1'b1, 2'd3, 3'd2);
        hwdata = 32'hD000_0000;
        check("full_w1_hready", 32'(hready_out), 32'd1);
        tick();
        set_addr(32'h8400_0008, 1'b1, 2'd3, 3'd2);
        hwdata = 32'hD000_0001;
        check("full_w2_hready", 32'(hready_out), 32'd1);
        tick();
        set_addr(32'h8400_0008, 1'b0, 2'd0, 3'd2);
        hwdata = 32'hD000_0002;
        check("full_w3_stall", 32'(hready_out), 32'd0);
        check("full_head_addr", req_addr, 32'h8400_0000);
        check("full_head_sel", 32'(req_sel), 32'd2);
        check("full_head_wdata", req_wdata, 32'hD000_0000);
        tick();
        check("full_w3_still_stall", 32'(hready_out), 32'd0);
        req_ready = 1'b1;
        tick();
        check("full_w3_complete", 32'(hready_out), 32'd1);
        check("full_pop2_addr", req_addr, 32'h8400_0004);
        check("full_pop2_wdata", req_wdata, 32'hD000_0001);
        tick();
        check("full_pop3_addr", req_addr, 32'h8400_0008);
        check("full_pop3_wdata", req_wdata, 32'hD000_0002);
        check("full_pop3_sel", 32'(req_sel), 32'd2);
        tick();
        check("full_drained", 32'(req_valid), 32'd0);

        // Read after write, response returned in the pop cycle
        req_ready = 1'b0;
        set_addr(32'h8800_0000, 1'b1, 2'd2, 3'd2);
        tick();
        set_addr(32'h8800_0000, 1'b0, 2'd2, 3'd2);
        hwdata = 32'hCAFE_0001;
        check("raw_w_hready", 32'(hready_out), 32'd1);
        tick();
        set_addr(32'h8800_0000, 1'b0, 2'd0, 3'd2);
        check("raw_rpush_stall", 32'(hready_out), 32'd0);
        check("raw_head_write", 32'(req_write), 32'd1);
        check("raw_head_wdata", req_wdata, 32'hCAFE_0001);
        check("raw_head_sel", 32'(req_sel), 32'd4);
        req_ready = 1'b1;
        tick();
        check("raw_rwait_stall", 32'(hready_out), 32'd0);
        check("raw_read_queued", 32'(req_valid), 32'd1);
        check("raw_read_write", 32'(req_write), 32'd0);
        check("raw_read_addr", req_addr, 32'h8800_0000);
        check("raw_read_sel", 32'(req_sel), 32'd4);
        rsp_valid = 1'b1;
        rsp_rdata = 32'h1234_5678;
        tick();
        rsp_valid = 1'b0;
        req_ready = 1'b0;
        check("raw_rdone_hready", 32'(hready_out), 32'd1);
        check("raw_hrdata", hrdata, 32'h1234_5678);
        check("raw_fifo_empty", 32'(req_valid), 32'd0);

        // Out-of-range read
        set_addr(32'h0000_0040, 1'b0, 2'd2, 3'd2);
        tick();
        set_addr(32'h0000_0040, 1'b0, 2'd0, 3'd2);
        if (ERR_BUILD) begin
            check("oor_err1_hready", 32'(hready_out), 32'd0);
            check("oor_err1_hresp", 32'(hresp), 32'd1);
            tick();
            check("oor_err2_hready", 32'(hready_out), 32'd1);
            check("oor_err2_hresp", 32'(hresp), 32'd1);
        end else begin
            check("oor_hready", 32'(hready_out), 32'd1);
            check("oor_hresp", 32'(hresp), 32'd0);
            check("oor_hrdata", hrdata, 32'd0);
        end
        tick();
        check("oor_after_hresp", 32'(hresp), 32'd0);
        check("oor_no_push", 32'(req_valid), 32'd0);

        // Reset while a read waits with a full FIFO
        set_addr(32'h8000_0000, 1'b1, 2'd2, 3'd2);
        tick();
        set_addr(32'h8000_0100, 1'b0, 2'd2, 3'd2);
        hwdata = 32'h0BAD_F00D;
        tick();
        set_addr(32'h8000_0100, 1'b0, 2'd0, 3'd2);
        tick();
        check("rstmid_rwait_stall", 32'(hready_out), 32'd0);
        check("rstmid_fifo_busy", 32'(req_valid), 32'd1);
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        check("rstmid_req_valid", 32'(req_valid), 32'd0);
        check("rstmid_hready", 32'(hready_out), 32'd1);
        check("rstmid_hrdata", hrdata, 32'd0);
        rsp_valid = 1'b1;
        rsp_rdata = 32'hAAAA_5555;
        tick();
        rsp_valid = 1'b0;
        check("rstmid_rsp_ignored", hrdata, 32'd0);
        check("rstmid_hready_after", 32'(hready_out), 32'd1);

        // IDLE/BUSY beats interleaved in a burst never push
        for (int i = 0; i < 6; i++) begin
            set_addr(BASE + 32'(i) * 32'd4, 1'(i % 2), (i % 2 == 0) ? 2'd0 : 2'd1, 3'd2);
            check("idle_busy_hready", 32'(hready_out), 32'd1);
            tick();
        end
        set_addr(BASE, 1'b0, 2'd0, 3'd2);
        check("idle_busy_no_push", 32'(req_valid), 32'd0);
        tick();
        check("idle_busy_no_push2", 32'(req_valid), 32'd0);

        // Randomized traffic against the in-order transaction model
        do_reset();
        dp_active = 1'b0;
        dp_read   = 1'b0;
        dp_oor    = 1'b0;
        dp_rdata  = '0;
        rsp_wait  = 1'b0;
        rsp_cnt   = 0;
        for (int cyc = 0; cyc < 2080; cyc++) begin
            hr = hready_out;
            if (req_valid) begin
                check("rnd_req_expected", 32'(exp_q.size() != 0), 32'd1);
                if (req_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rnd_addr", req_addr, e.addr);
                    check("rnd_write", 32'(req_write), 32'(e.write));
                    check("rnd_size", 32'(req_size), 32'(e.size));
                    check("rnd_sel", 32'(req_sel), 32'(e.sel));
                    if (e.write) begin
                        check("rnd_wdata", req_wdata, e.wdata);
                    end else begin
                        rsp_wait = 1'b1;
                        rsp_cnt  = int'($urandom_range(0, 3));
                    end
                end
            end
            if (dp_active && hr) begin
                check("rnd_hresp", 32'(hresp), (dp_oor && ERR_BUILD) ? 32'd1 : 32'd0);
                if (dp_read && !(dp_oor && ERR_BUILD)) check("rnd_hrdata", hrdata, dp_rdata);
            end
            acc       = hr && htrans[1];
            nxt_wdata = $urandom;
            if (acc && in_window(haddr)) begin
                e.addr  = haddr;
                e.wdata = nxt_wdata;
                e.write = hwrite;
                e.size  = hsize;
                e.sel   = exp_sel(haddr);
                exp_q.push_back(e);
            end
            tick();
            rsp_valid = 1'b0;
            if (hr) begin
                dp_active = acc;
                dp_read   = acc && !hwrite;
                dp_oor    = acc && !in_window(haddr);
                dp_rdata  = '0;
                hwdata    = (acc && hwrite) ? nxt_wdata : $urandom;
                if (cyc >= 2000) set_addr(haddr, hwrite, 2'd0, hsize);
                else             rand_addr();
            end
            if (rsp_wait) begin
                if (rsp_cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_rdata = $urandom;
                    dp_rdata  = rsp_rdata;
                    rsp_wait  = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end else if (!(dp_active && dp_read) && $urandom_range(0, 7) == 0) begin
                rsp_valid = 1'b1;
                rsp_rdata = $urandom;
            end
            req_ready = ($urandom_range(0, 3) != 0);
        end
        check("rnd_model_drained", 32'(exp_q.size()), 32'd0);
        check("rnd_fifo_drained", 32'(req_valid), 32'd0);
        check("rnd_bus_ready", 32'(hready_out), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
